// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for an eight-digit, common-anode,
// seven-segment display. Each 100 Hz scan_tick advances the scan by one
// digit slot. Every slot starts with a blanking gap (all anodes off) to
// kill ghosting, then drives the selected anode with the decoded segments.
// The eight digits are captured into a snapshot at the start of each frame,
// so a value that changes mid-frame never shows half old and half new.
//
// Parameters
//   BLANK_CYCLES  clk cycles of all-anodes-off at the start of a slot (1..15)
//   LZS_DEFAULT   leading-zero-suppression setting held before the first
//                 frame is captured after reset
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   synchronous, active-high reset
//   scan_tick   in   1   one-cycle slot-advance strobe
//   digits      in   32  eight BCD nibbles, bits 31:28 = leftmost digit 7
//   digit_en    in   8   per-digit enable, 0 keeps that digit dark
//   lzs_en      in   1   leading-zero-suppression enable
//   an          out  8   active-low anodes, bit i = digit i
//   seg         out  7   active-low segments {G,F,E,D,C,B,A}
//   digit_idx   out  3   current slot index
//   frame_done  out  1   one-cycle pulse when the slot index wraps 7 -> 0
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int unsigned BLANK_CYCLES = 4,
  parameter bit          LZS_DEFAULT  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_tick,
  input  logic [31:0] digits,
  input  logic [7:0]  digit_en,
  input  logic        lzs_en,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_e;

  // Blank counter value at which the gap has lasted BLANK_CYCLES cycles.
  localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYCLES - 1);

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e      state_q;
  logic [2:0]  idx_q;
  logic [3:0]  blank_cnt_q;
  logic [31:0] snap_q;
  // Suppression setting is captured together with the digits so one frame
  // is always rendered with one consistent rule.
  logic        lzs_q;
  logic [7:0]  an_q;
  logic [6:0]  seg_q;
  logic        frame_done_q;

  // -------------------------------------------------------------------------
  // Slot rendering: what the current slot should show while driven.
  // Derived purely from registered state (snapshot, index, latched LZS)
  // plus the live per-digit enable.
  // -------------------------------------------------------------------------
  logic [3:0]  cur_nib_d;
  logic [31:0] upper_nibs_d;
  logic        lead_zero_d;
  logic        dark_d;
  logic [6:0]  decoded_d;
  logic [7:0]  drive_an_d;
  logic [6:0]  drive_seg_d;

  assign cur_nib_d    = snap_q[{idx_q, 2'b00} +: 4];
  // Nibbles idx..7 moved down to the bottom; zero means the current digit
  // and everything to its left are zero.
  assign upper_nibs_d = snap_q >> {idx_q, 2'b00};
  // Digit 0 is exempt so that an all-zero value still shows a single "0".
  assign lead_zero_d  = lzs_q && (idx_q != 3'd0) && (upper_nibs_d == 32'd0);
  assign dark_d       = !digit_en[idx_q] || lead_zero_d;

  // NOTE: every output of a combinational block gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    decoded_d = 7'h3F;
    case (cur_nib_d)
      4'd0:    decoded_d = 7'h40;
      4'd1:    decoded_d = 7'h79;
      4'd2:    decoded_d = 7'h24;
      4'd3:    decoded_d = 7'h30;
      4'd4:    decoded_d = 7'h19;
      4'd5:    decoded_d = 7'h12;
      4'd6:    decoded_d = 7'h02;
      4'd7:    decoded_d = 7'h78;
      4'd8:    decoded_d = 7'h00;
      4'd9:    decoded_d = 7'h10;
      default: decoded_d = 7'h3F;  // non-BCD nibble shows a dash
    endcase
  end

  assign drive_an_d  = dark_d ? AN_OFF  : ~(8'b0000_0001 << idx_q);
  assign drive_seg_d = dark_d ? SEG_OFF : decoded_d;

  // -------------------------------------------------------------------------
  // Scan FSM with registered outputs.
  //
  // A tick accepted at edge N turns the anodes off at that same edge and
  // starts the blank counter at 0; the counter reaches BLANK_LAST at edge
  // N+BLANK_CYCLES-1, so the new anode is loaded at edge N+BLANK_CYCLES.
  // Ticks arriving during BLANK are dropped, not remembered.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only,
  // so every register samples the pre-edge values of all the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      blank_cnt_q  <= 4'd0;
      // NOTE: the snapshot is an ordinary 32-bit register, not a memory, so
      // clearing it in reset is cheap and keeps outputs defined from reset.
      snap_q       <= 32'd0;
      lzs_q        <= LZS_DEFAULT;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          an_q  <= AN_OFF;
          seg_q <= SEG_OFF;
          if (scan_tick) begin
            // Start of the very first frame: slot 0 with a fresh snapshot.
            idx_q       <= 3'd0;
            snap_q      <= digits;
            lzs_q       <= lzs_en;
            blank_cnt_q <= 4'd0;
            state_q     <= S_BLANK;
          end
        end

        S_BLANK: begin
          if (blank_cnt_q == BLANK_LAST) begin
            state_q <= S_DRIVE;
            an_q    <= drive_an_d;
            seg_q   <= drive_seg_d;
          end else begin
            blank_cnt_q <= blank_cnt_q + 4'd1;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
          end
        end

        S_DRIVE: begin
          if (scan_tick) begin
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            blank_cnt_q <= 4'd0;
            state_q     <= S_BLANK;
            idx_q       <= idx_q + 3'd1;  // 7 wraps to 0 naturally
            if (idx_q == 3'd7) begin
              // Entering slot 0 of a new frame: refresh the snapshot here
              // and nowhere else, so slots 1..7 always match slot 0.
              snap_q       <= digits;
              lzs_q        <= lzs_en;
              frame_done_q <= 1'b1;
            end
          end else begin
            // Keep tracking digit_en while the slot is lit.
            an_q  <= drive_an_d;
            seg_q <= drive_seg_d;
          end
        end

        default: begin
          state_q <= S_IDLE;
          an_q    <= AN_OFF;
          seg_q   <= SEG_OFF;
        end
      endcase
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Self-checking bench for display_scan_ctrl. A time-based reference model
// (time of the last accepted tick, slot number, frame snapshot) predicts
// every output every cycle; scenario tasks add directed checks on slot
// contents, anode-low durations and frame pulses.
// ---------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scan_tick = 1'b0;
  logic [31:0] digits = 32'd0;
  logic [7:0]  digit_en = 8'hFF;
  logic        lzs_en = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [2:0]  digit_idx;
  logic        frame_done;

  display_scan_ctrl #(
    .BLANK_CYCLES (BC),
    .LZS_DEFAULT  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_tick  (scan_tick),
    .digits     (digits),
    .digit_en   (digit_en),
    .lzs_en     (lzs_en),
    .an         (an),
    .seg        (seg),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic [2:0] idx;
    logic       fd;
  } out_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int          m_cyc    = 0;
  bit          m_active = 1'b0;
  int          m_t0     = 0;
  int          m_idx    = 0;
  logic [31:0] m_snap   = 32'd0;
  bit          m_fd     = 1'b0;
  logic [7:0]  m_en     = 8'hFF;
  bit          m_lzs    = 1'b0;

  // Per-scenario statistics.
  int         low_cnt [8];
  logic [7:0] slot_an [8];
  logic [6:0] slot_seg[8];
  int         fd_cnt;

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    case (nib)
      4'd0: return 7'h40;  4'd1: return 7'h79;
      4'd2: return 7'h24;  4'd3: return 7'h30;
      4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;
      4'd8: return 7'h00;  4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Apply the rules at one clock edge using the inputs held across it.
  task automatic model_edge();
    m_cyc++;
    m_en  = digit_en;
    m_lzs = lzs_en;
    if (reset) begin
      m_active = 1'b0;
      m_idx    = 0;
      m_snap   = 32'd0;
      m_fd     = 1'b0;
    end else begin
      m_fd = 1'b0;
      if (scan_tick) begin
        if (!m_active) begin
          m_active = 1'b1;
          m_t0     = m_cyc;
          m_idx    = 0;
          m_snap   = digits;
        end else if (m_cyc - m_t0 > BC) begin
          // Slot is lit (blank gap over), so the tick is accepted.
          m_t0 = m_cyc;
          if (m_idx == 7) begin
            m_idx  = 0;
            m_snap = digits;
            m_fd   = 1'b1;
          end else begin
            m_idx = m_idx + 1;
          end
        end
      end
    end
  endtask

  function automatic out_t model_out();
    out_t        o;
    logic [31:0] upper;
    logic [3:0]  nib;
    bit          dark;
    o.idx = 3'(m_idx);
    o.fd  = m_fd;
    o.an  = 8'hFF;
    o.seg = 7'h7F;
    if (m_active && (m_cyc - m_t0 >= BC)) begin
      upper = m_snap >> (4 * m_idx);
      nib   = upper[3:0];
      dark  = !m_en[m_idx] || (m_lzs && m_idx != 0 && upper == 32'd0);
      if (!dark) begin
        o.an  = ~(8'd1 << m_idx);
        o.seg = seg_of(nib);
      end
    end
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.an  = an;
    o.seg = seg;
    o.idx = digit_idx;
    o.fd  = frame_done;
    return o;
  endfunction

  function automatic string fmt_out(input out_t o);
    return $sformatf("an=%h seg=%h idx=%0d fd=%b", o.an, o.seg, o.idx, o.fd);
  endfunction

  function automatic logic [31:0] rand_digits();
    logic [31:0] d;
    int          z;
    d = $urandom;
    z = $urandom_range(0, 8);
    for (int i = 0; i < z; i++) d[31 - 4 * i -: 4] = 4'd0;
    return d;
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < 8; i++) begin
      low_cnt[i]  = 0;
      slot_an[i]  = 8'hxx;
      slot_seg[i] = 7'hxx;
    end
    fd_cnt = 0;
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step(input string tag);
    out_t got;
    out_t exp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    got = dut_out();
    exp = model_out();
    n_checks++;
    if (got !== exp)
      $display("FAIL %s cyc=%0d got %s exp %s", tag, m_cyc, fmt_out(got), fmt_out(exp));
    else
      n_pass++;
    if (frame_done === 1'b1) fd_cnt++;
    for (int i = 0; i < 8; i++) if (an[i] === 1'b0) low_cnt[i]++;
  endtask

  // n slots, one tick at the start of each period-cycle slot.
  task automatic run_slots(input string tag, input int n, input int period);
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < period; k++) begin
        scan_tick = (k == 0);
        step(tag);
        if (k == BC) begin
          slot_an[m_idx]  = an;
          slot_seg[m_idx] = seg;
        end
      end
    end
    scan_tick = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    step(tag);
    reset = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset     = 1'b1;
    scan_tick = 1'b1;  // must be ignored while reset is high
    for (int i = 0; i < 2; i++) begin
      step("reset");
      n_checks++;
      if (dut_out() !== out_t'({8'hFF, 7'h7F, 3'd0, 1'b0}))
        $display("FAIL reset_state got %s exp an=ff seg=7f idx=0 fd=0", fmt_out(dut_out()));
      else
        n_pass++;
    end
    reset     = 1'b0;
    scan_tick = 1'b0;
    for (int i = 0; i < 8; i++) step("idle");
    n_checks++;
    if (an !== 8'hFF) $display("FAIL idle_dark got an=%h exp an=ff", an);
    else n_pass++;
  endtask

  task automatic test_basic_scan();
    logic [6:0] exp_seg[8];
    exp_seg = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    digits   = 32'h12345678;
    digit_en = 8'hFF;
    lzs_en   = 1'b0;
    clear_stats();
    run_slots("basic", 8, 20);
    n_checks++;
    if (slot_an[0] !== 8'hFE || slot_seg[0] !== 7'h00)
      $display("FAIL basic_slot0 got an=%h seg=%h exp an=fe seg=00", slot_an[0], slot_seg[0]);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (slot_seg[i] !== exp_seg[i] || low_cnt[i] !== 16)
        $display("FAIL basic_slot%0d got seg=%h low=%0d exp seg=%h low=16",
                 i, slot_seg[i], low_cnt[i], exp_seg[i]);
      else n_pass++;
    end
    n_checks++;
    if (fd_cnt !== 0) $display("FAIL basic_no_fd got %0d pulses exp 0", fd_cnt);
    else n_pass++;
    run_slots("basic_wrap", 1, 20);
    n_checks++;
    if (fd_cnt !== 1) $display("FAIL basic_wrap_fd got %0d pulses exp 1", fd_cnt);
    else n_pass++;
  endtask

  task automatic test_lzs();
    digits   = 32'h00000305;
    lzs_en   = 1'b1;
    digit_en = 8'hFF;
    do_reset("lzs_rst");
    clear_stats();
    run_slots("lzs", 8, 12);
    for (int i = 3; i < 8; i++) begin
      n_checks++;
      if (low_cnt[i] !== 0) $display("FAIL lzs_dark%0d got low=%0d exp low=0", i, low_cnt[i]);
      else n_pass++;
    end
    n_checks++;
    if (slot_seg[2] !== 7'h30 || slot_seg[1] !== 7'h40 || slot_seg[0] !== 7'h12)
      $display("FAIL lzs_digits got %h %h %h exp 30 40 12", slot_seg[2], slot_seg[1], slot_seg[0]);
    else n_pass++;
    digits = 32'd0;
    clear_stats();
    run_slots("lzs_zero", 8, 12);
    n_checks++;
    if (slot_an[0] !== 8'hFE || slot_seg[0] !== 7'h40)
      $display("FAIL lzs_zero_d0 got an=%h seg=%h exp an=fe seg=40", slot_an[0], slot_seg[0]);
    else n_pass++;
    for (int i = 1; i < 8; i++) begin
      n_checks++;
      if (low_cnt[i] !== 0) $display("FAIL lzs_zero_dark%0d got low=%0d exp low=0", i, low_cnt[i]);
      else n_pass++;
    end
  endtask

  task automatic test_snapshot();
    digits   = 32'h11111111;
    lzs_en   = 1'b0;
    digit_en = 8'hFF;
    do_reset("snap_rst");
    clear_stats();
    run_slots("snap", 4, 14);  // ends lit in slot 3
    digits = 32'h22222222;
    step("snap_chg");
    n_checks++;
    if (seg !== 7'h79) $display("FAIL snap_no_tear got seg=%h exp seg=79", seg);
    else n_pass++;
    run_slots("snap", 4, 14);  // slots 4..7
    for (int i = 3; i < 8; i++) begin
      n_checks++;
      if (slot_seg[i] !== 7'h79) $display("FAIL snap_slot%0d got seg=%h exp seg=79", i, slot_seg[i]);
      else n_pass++;
    end
    run_slots("snap_wrap", 1, 14);
    n_checks++;
    if (slot_seg[0] !== 7'h24 || fd_cnt !== 1)
      $display("FAIL snap_wrap got seg=%h fd=%0d exp seg=24 fd=1", slot_seg[0], fd_cnt);
    else n_pass++;
  endtask

  task automatic test_blank_tick();
    logic [2:0] exp_idx;
    exp_idx   = 3'(m_idx + 1);
    scan_tick = 1'b1; step("btick");
    scan_tick = 1'b0; step("btick");
    scan_tick = 1'b1; step("btick");  // 2nd cycle of BLANK: dropped
    scan_tick = 1'b0;
    n_checks++;
    if (digit_idx !== exp_idx) $display("FAIL btick_idx got %0d exp %0d", digit_idx, exp_idx);
    else n_pass++;
    step("btick");
    n_checks++;
    if (an !== 8'hFF) $display("FAIL btick_still_blank got an=%h exp an=ff", an);
    else n_pass++;
    step("btick");
    n_checks++;
    if (an !== ~(8'd1 << exp_idx)) $display("FAIL btick_drive got an=%h exp an=%h", an, ~(8'd1 << exp_idx));
    else n_pass++;
    for (int i = 0; i < 6; i++) step("btick");
  endtask

  task automatic test_reset_mid_drive();
    int lit;
    digits   = 32'h22222222;
    digit_en = 8'hFF;
    do_reset("mrst_rst");
    clear_stats();
    run_slots("mrst", 6, 20);  // lit in slot 5
    reset = 1'b1;
    step("mrst");
    reset = 1'b0;
    n_checks++;
    if (an !== 8'hFF || digit_idx !== 3'd0 || frame_done !== 1'b0)
      $display("FAIL mrst_after got an=%h idx=%0d fd=%b exp an=ff idx=0 fd=0", an, digit_idx, frame_done);
    else n_pass++;
    lit = 0;
    for (int i = 0; i < 30; i++) begin
      step("mrst_idle");
      if (an !== 8'hFF) lit++;
    end
    n_checks++;
    if (lit !== 0) $display("FAIL mrst_quiet got %0d lit cycles exp 0", lit);
    else n_pass++;
    run_slots("mrst_restart", 1, 10);
    n_checks++;
    if (slot_an[0] !== 8'hFE || slot_seg[0] !== 7'h24)
      $display("FAIL mrst_restart got an=%h seg=%h exp an=fe seg=24", slot_an[0], slot_seg[0]);
    else n_pass++;
  endtask

  task automatic test_dash();
    digits   = 32'h8765432C;
    digit_en = 8'h0F;
    lzs_en   = 1'b0;
    do_reset("dash_rst");
    clear_stats();
    run_slots("dash", 8, 16);
    for (int i = 4; i < 8; i++) begin
      n_checks++;
      if (low_cnt[i] !== 0) $display("FAIL dash_dark%0d got low=%0d exp low=0", i, low_cnt[i]);
      else n_pass++;
    end
    n_checks++;
    if (slot_an[0] !== 8'hFE || slot_seg[0] !== 7'h3F || low_cnt[1] !== 12)
      $display("FAIL dash_d0 got an=%h seg=%h low1=%0d exp an=fe seg=3f low1=12",
               slot_an[0], slot_seg[0], low_cnt[1]);
    else n_pass++;
  endtask

  task automatic test_random();
    lzs_en = 1'($urandom_range(0, 1));
    do_reset("rnd_rst");
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      if (reset) lzs_en = 1'($urandom_range(0, 1));
      scan_tick = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) digits = rand_digits();
      if ($urandom_range(0, 63) == 0) digit_en = 8'($urandom);
      step("random");
    end
    reset     = 1'b0;
    scan_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_lzs();
    test_snapshot();
    test_blank_tick();
    test_reset_mid_drive();
    test_dash();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
